spram_bist: RTL
===============

Name: spram_bist

Overview:
- Built-in self-test initiator for the single-port 32-bit SRAM macro; drives the RAM's clk/addr/ce/we/d port and consumes its registered q.
- Runs a March-style sequence (write, read/invert, read/restore descending, final read) over every word.
- Reports pass/fail, first failing address/data and a saturating error count.
- Sits between the SoC debug/boot control logic and the RAM, muxed ahead of the normal bus port; the mux is outside this block.

Parameters:
- size, 'h80, RAM size in bytes; N = size/4 words; must be a power of two, at least 8.
- addr_width, $clog2(size) - 2, word address width.
- pattern, 32'hA5A5_5A5A, background data word P; the inverse background is ~P.
- err_width, 8, width of the error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle run request
- busy  out  1  test in progress
- done  out  1  test finished; held until next start or rst
- pass  out  1  valid when done=1; 1 means zero errors
- fail_addr  out  addr_width  word address of the first miscompare
- fail_data  out  32  q value read at the first miscompare
- err_cnt  out  err_width  miscompare count, saturating
- ram_addr  out  addr_width  RAM word address
- ram_ce  out  1  RAM chip enable
- ram_we  out  4  RAM byte write enables
- ram_d  out  32  RAM write data
- ram_q  in  32  RAM read data, valid the cycle after a ce=1, we=0 access

Behaviour:
- Reset: every output is 0; state is IDLE.
- Start: start is accepted in IDLE or DONE. It clears err_cnt, fail_addr, fail_data, pass and done, and sets busy on the next edge. Start is ignored while busy.
- States: IDLE -> WR_ASC -> RDW_ASC -> RDW_DESC -> RD_CHK -> DONE.
- WR_ASC: N cycles. Addresses 0..N-1, ce=1, we=4'hF, d=P.
- RDW_ASC: two cycles per address, ascending.
  - Cycle A: ce=1, we=0.
  - Cycle B: ce=1, we=4'hF, d=~P, same addr. Compare ram_q against P in cycle B.
- RDW_DESC: same two-cycle structure, addresses N-1..0. Expect ~P, write P.
- RD_CHK: N read cycles ascending, ce=1, we=0, expect P. Compare the read of cycle k in cycle k+1.
  - The compare of the last read happens in one trailing cycle with ce=0.
  - Then enter DONE.
- Total busy duration is 6N+1 cycles. In the cycle after the final compare: busy=0, done=1, and pass=(err_cnt==0), counting the final compare's contribution.
- ram_ce=0, ram_we=0, ram_d=0 in IDLE, DONE and the trailing compare cycle.
- ram_addr holds its last value when ce=0.
- Miscompare:
  - err_cnt increments by 1 and saturates at 2^err_width-1.
  - fail_addr/fail_data are captured only on the first miscompare of a run.
  - fail_addr is the address of the compared read, not the current ram_addr.
- Address wrap: counters stop at N-1 (ascending) or 0 (descending) and move to the next state. No wrap-around is ever issued.
- rst mid-run: on the next edge go to IDLE with all outputs 0. RAM contents are undefined afterwards.
- start and rst together: rst wins.
- DONE persists until start or rst; a new start reruns the full sequence.

Test Plan:
- size='h80 (N=32) with a fault-free RAM model, pulse start:
  - busy is high for exactly 193 cycles, then done=1, pass=1, err_cnt=0.
  - RAM ends holding 32'hA5A5_5A5A in all words.
- Bus trace check:
  - The first 32 accesses are we=4'hF, addr 0..31.
  - RDW_ASC starts with addr0 (we=0, then we=4'hF, d=32'h5A5A_A5A5).
  - RDW_DESC starts at addr 31.
- Stuck-at-1 on bit 0 of word 5, with pattern bit 0 = 0:
  - done with pass=0, fail_addr=5.
  - fail_data=32'hA5A5_5A5B, captured in RDW_ASC.
  - err_cnt=2: one miscompare each in RDW_ASC and RD_CHK.
- Every word stuck at 0, err_width=2:
  - err_cnt saturates at 3.
  - fail_addr=0, pass=0.
- Assert rst at cycle 50 of a run:
  - Next cycle busy=0, done=0, ram_ce=0.
  - A later start completes normally with pass=1.
- Pulse start repeatedly while busy: no effect, duration stays 193 cycles. Pulse start in DONE: rerun begins, done clears on the next edge.

Source files
------------

// File: rtl/spram_bist.sv
// rtl/spram_bist.sv - March-style built-in self-test initiator for a single-port 32-bit SRAM
//
// Purpose: on a start pulse, runs write / read+invert ascending / read+restore descending /
// final read over every word of the RAM, and reports pass/fail, the first failing
// address and data, and a saturating miscompare count.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             single-cycle run request (accepted in IDLE or DONE)
//   busy, done, pass  run status; pass is valid while done=1
//   fail_addr/data    word address and q value of the first miscompare of a run
//   err_cnt           saturating miscompare count
//   ram_addr/ce/we/d  RAM request port
//   ram_q             RAM read data, valid the cycle after a read access
module spram_bist #(
  parameter int          size       = 'h80,
  parameter int          addr_width = $clog2(size) - 2,
  parameter logic [31:0] pattern    = 32'hA5A5_5A5A,
  parameter int          err_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [addr_width-1:0] fail_addr,
  output logic [31:0]           fail_data,
  output logic [err_width-1:0]  err_cnt,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_ce,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_d,
  input  logic [31:0]           ram_q
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ASC   = 3'd1;
  localparam logic [2:0] S_RDW_ASC  = 3'd2;
  localparam logic [2:0] S_RDW_DESC = 3'd3;
  localparam logic [2:0] S_RD_CHK   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [addr_width-1:0] last_addr = addr_width'(size / 4 - 1);
  localparam logic [err_width-1:0]  err_max   = '1;

  logic [2:0]            state;
  logic [addr_width-1:0] addr;
  logic                  phase;        // 0: read cycle, 1: compare + write-back cycle
  logic                  cmp_pending;  // RD_CHK: a read was issued last cycle
  logic [addr_width-1:0] cmp_addr;     // RD_CHK: address of that read
  logic                  tail;         // RD_CHK: trailing compare-only cycle

  logic                  cmp_en;
  logic [31:0]           cmp_exp;
  logic [addr_width-1:0] cmp_at;
  logic                  miss;
  logic [err_width-1:0]  err_next;

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign ram_addr = addr;

  always_comb begin
    ram_ce  = 1'b0;
    ram_we  = 4'h0;
    ram_d   = 32'h0;
    cmp_en  = 1'b0;
    cmp_exp = pattern;
    cmp_at  = addr;
    case (state)
      S_WR_ASC: begin
        ram_ce = 1'b1;
        ram_we = 4'hF;
        ram_d  = pattern;
      end
      S_RDW_ASC: begin
        ram_ce = 1'b1;
        if (phase) begin
          ram_we = 4'hF;
          ram_d  = ~pattern;
          cmp_en = 1'b1;
        end
      end
      S_RDW_DESC: begin
        ram_ce  = 1'b1;
        cmp_exp = ~pattern;
        if (phase) begin
          ram_we = 4'hF;
          ram_d  = pattern;
          cmp_en = 1'b1;
        end
      end
      S_RD_CHK: begin
        // Reads are pipelined: the data for the read issued last cycle is checked now.
        ram_ce = ~tail;
        cmp_en = tail | cmp_pending;
        cmp_at = cmp_addr;
      end
      default: ;
    endcase
  end

  assign miss     = cmp_en && (ram_q != cmp_exp);
  assign err_next = (miss && (err_cnt != err_max)) ? err_cnt + 1'b1 : err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      phase       <= 1'b0;
      cmp_pending <= 1'b0;
      cmp_addr    <= '0;
      tail        <= 1'b0;
      err_cnt     <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      pass        <= 1'b0;
      done        <= 1'b0;
    end else begin
      err_cnt <= err_next;
      // err_cnt never returns to zero within a run, so zero marks "no miscompare yet".
      if (miss && (err_cnt == '0)) begin
        fail_addr <= cmp_at;
        fail_data <= ram_q;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_WR_ASC;
            addr      <= '0;
            phase     <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
            done      <= 1'b0;
          end
        end
        S_WR_ASC: begin
          if (addr == last_addr) begin
            state <= S_RDW_ASC;
            addr  <= '0;
            phase <= 1'b0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_RDW_ASC: begin
          phase <= ~phase;
          if (phase) begin
            if (addr == last_addr) state <= S_RDW_DESC;
            else                   addr  <= addr + 1'b1;
          end
        end
        S_RDW_DESC: begin
          phase <= ~phase;
          if (phase) begin
            if (addr == '0) begin
              state       <= S_RD_CHK;
              cmp_pending <= 1'b0;
              tail        <= 1'b0;
            end else begin
              addr <= addr - 1'b1;
            end
          end
        end
        S_RD_CHK: begin
          if (tail) begin
            state       <= S_DONE;
            tail        <= 1'b0;
            cmp_pending <= 1'b0;
            done        <= 1'b1;
            pass        <= (err_next == '0);
          end else begin
            cmp_pending <= 1'b1;
            cmp_addr    <= addr;
            if (addr == last_addr) tail <= 1'b1;
            else                   addr <= addr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
